// File: rtl/xbar_pkg.sv
// Shared crossbar types and sizing helpers for the master/slave request path.
package xbar_pkg;

    localparam int unsigned DEFAULT_QTY_OF_MASTERS = 4;
    localparam int unsigned DEFAULT_QTY_OF_SLAVES  = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the next master after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    localparam int unsigned MIDX_W = idx_width(DEFAULT_QTY_OF_MASTERS);
    localparam int unsigned SIDX_W = idx_width(DEFAULT_QTY_OF_SLAVES);

    typedef logic [MIDX_W-1:0] master_idx_t;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request at or after the start pointer, wrapping.
module rr_priority_picker
    import xbar_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic           hit;
    int unsigned    offset;
    int unsigned    idx_v;

    // Rotating a doubled copy puts the pointer position at bit 0, so a plain
    // lowest-set-bit search gives the distance from the pointer.
    always_comb begin
        doubled = {req_i, req_i} >> ptr_i;
        rotated = doubled[N-1:0];
        found_o = |rotated;
        hit     = 1'b0;
        offset  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!hit && rotated[i]) begin
                hit    = 1'b1;
                offset = i;
            end
        end
        idx_v = 32'(ptr_i) + offset;
        if (idx_v >= N) begin
            idx_v = idx_v - N;
        end
        idx_o    = W'(idx_v);
        onehot_o = found_o ? (N'(1) << idx_v) : '0;
    end

endmodule

// File: rtl/slave_request_arbiter.sv
// Per-slave round-robin arbiter: grants one master, holds until ack, steers ack back.
// Optional stalled-slave release is enabled by defining SLAVE_ARB_TIMEOUT_EN.
module slave_request_arbiter
    import xbar_pkg::*;
#(
    parameter int unsigned  QTY_OF_MASTERS = DEFAULT_QTY_OF_MASTERS,
    parameter int unsigned  TIMEOUT_CYCLES = 16,
    localparam int unsigned IDX_W          = idx_width(QTY_OF_MASTERS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [QTY_OF_MASTERS-1:0] req_i,
    input  logic                      slave_ack_i,
    output logic [QTY_OF_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]          grant_idx_o,
    output logic                      grant_valid_o,
    output logic [QTY_OF_MASTERS-1:0] master_ack_o,
    output logic                      timeout_err_o
);

    localparam logic [QTY_OF_MASTERS-1:0] GRANT_LSB = QTY_OF_MASTERS'(1);

    arb_state_e                state_q;
    logic [QTY_OF_MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]          grant_idx_q;
    logic                      grant_valid_q;
    logic [IDX_W-1:0]          rr_ptr_q;

    logic [IDX_W-1:0]          next_ptr;
    logic [IDX_W-1:0]          arb_ptr;
    logic                      arb_en;
    logic                      release_c;
    logic                      granted_req;
    logic                      timeout_hit;

    logic                      pick_found;
    logic [IDX_W-1:0]          pick_idx;
    logic [QTY_OF_MASTERS-1:0] pick_onehot;

    assign granted_req = |(req_i & grant_q);
    assign next_ptr    = IDX_W'(wrap_inc(32'(grant_idx_q), QTY_OF_MASTERS));

`ifdef SLAVE_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = idx_width(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_err_q;

    assign timeout_hit   = (state_q == BUSY) && !slave_ack_i &&
                           (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_hit   = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    // Every way out of BUSY re-arbitrates in the same cycle from the slot after
    // the released master, so back-to-back grants have no idle bubble.
    always_comb begin
        arb_en    = 1'b0;
        release_c = 1'b0;
        arb_ptr   = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                arb_en = 1'b1;
            end
            BUSY: begin
                if (slave_ack_i || !granted_req || timeout_hit) begin
                    release_c = 1'b1;
                    arb_en    = 1'b1;
                    arb_ptr   = next_ptr;
                end
            end
            default: begin
                arb_en = 1'b1;
            end
        endcase
    end

    rr_priority_picker #(
        .N (QTY_OF_MASTERS),
        .W (IDX_W)
    ) u_picker (
        .req_i    (req_i),
        .ptr_i    (arb_ptr),
        .found_o  (pick_found),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= '0;
`ifdef SLAVE_ARB_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            if (arb_en) begin
                if (release_c) begin
                    rr_ptr_q <= next_ptr;
                end
                if (pick_found) begin
                    state_q       <= BUSY;
                    grant_q       <= pick_onehot;
                    grant_idx_q   <= pick_idx;
                    grant_valid_q <= 1'b1;
                end else begin
                    state_q       <= IDLE;
                    grant_q       <= '0;
                    grant_idx_q   <= '0;
                    grant_valid_q <= 1'b0;
                end
            end
`ifdef SLAVE_ARB_TIMEOUT_EN
            to_cnt_q      <= arb_en ? '0 : to_cnt_q + 1'b1;
            timeout_err_q <= timeout_hit;
`endif
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = grant_idx_q;
    assign grant_valid_o = grant_valid_q;
    // grant_q is zero in IDLE, so an ack there is dropped.
    assign master_ack_o  = grant_q & {QTY_OF_MASTERS{slave_ack_i}};

    a_params_ok: assert property (@(posedge clk) (TIMEOUT_CYCLES >= 2) && (QTY_OF_MASTERS >= 1));
    a_onehot0:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_valid:     assert property (@(posedge clk) disable iff (!rst_n) grant_valid_q == (|grant_q));
    a_idx:       assert property (@(posedge clk) disable iff (!rst_n)
                                  !grant_valid_q || (grant_q == (GRANT_LSB << grant_idx_q)));

endmodule

// File: tb/tb_slave_request_arbiter.sv
// Directed bench for slave_request_arbiter: N=4 main instance plus N=3 and N=1 builds.
module tb_slave_request_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic [1:0] gidx;
    logic       gvalid;
    logic [3:0] mack;
    logic       terr;

    logic [2:0] req3;
    logic       ack3;
    logic [2:0] grant3;
    logic [1:0] gidx3;
    logic       gvalid3;
    logic [2:0] mack3;
    logic       terr3;

    logic [0:0] req1;
    logic       ack1;
    logic [0:0] grant1;
    logic [0:0] gidx1;
    logic       gvalid1;
    logic [0:0] mack1;
    logic       terr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slave_request_arbiter #(.QTY_OF_MASTERS(4), .TIMEOUT_CYCLES(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .slave_ack_i(ack), .grant_o(grant),
        .grant_idx_o(gidx), .grant_valid_o(gvalid), .master_ack_o(mack), .timeout_err_o(terr)
    );

    slave_request_arbiter #(.QTY_OF_MASTERS(3), .TIMEOUT_CYCLES(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .slave_ack_i(ack3), .grant_o(grant3),
        .grant_idx_o(gidx3), .grant_valid_o(gvalid3), .master_ack_o(mack3), .timeout_err_o(terr3)
    );

    slave_request_arbiter #(.QTY_OF_MASTERS(1), .TIMEOUT_CYCLES(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req1), .slave_ack_i(ack1), .grant_o(grant1),
        .grant_idx_o(gidx1), .grant_valid_o(gvalid1), .master_ack_o(mack1), .timeout_err_o(terr1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [31:0] g, input logic [31:0] i, input logic [31:0] v);
        check({tag, ".grant"}, 32'(grant), g);
        check({tag, ".idx"},   32'(gidx),  i);
        check({tag, ".valid"}, 32'(gvalid), v);
    endtask

    task automatic chk3(input string tag, input logic [31:0] g, input logic [31:0] i, input logic [31:0] v);
        check({tag, ".grant3"}, 32'(grant3), g);
        check({tag, ".idx3"},   32'(gidx3),  i);
        check({tag, ".valid3"}, 32'(gvalid3), v);
    endtask

    int unsigned order4[5] = '{0, 1, 2, 3, 0};
    int unsigned order3[4] = '{0, 1, 2, 0};

    initial begin
        rst_n = 1'b0;
        req = '0;  ack = 1'b0;
        req3 = '0; ack3 = 1'b0;
        req1 = '0; ack1 = 1'b0;
        tick();
        tick();

        chk4("reset", 0, 0, 0);
        check("reset.mack", 32'(mack), 0);
        check("reset.err", 32'(terr), 0);
        chk3("reset", 0, 0, 0);
        rst_n = 1'b1;

        // single requester, ack forwarded in the same cycle
        req = 4'b0100;
        tick();
        chk4("t1.grant", 32'h4, 2, 1);
        check("t1.mack_noack", 32'(mack), 0);
        ack = 1'b1;
        #1;
        check("t1.mack", 32'(mack), 32'h4);
        tick();
        chk4("t1.regrant", 32'h4, 2, 1);

        // async reset while BUSY with ack asserted
        rst_n = 1'b0;
        #1;
        chk4("t6.rst", 0, 0, 0);
        check("t6.rst_mack", 32'(mack), 0);
        ack = 1'b0;
        req = '0;
        tick();
        rst_n = 1'b1;

        // all requesting, ack every third cycle: 0,1,2,3,0 with no bubbles
        req = 4'b1111;
        tick();
        for (int unsigned k = 0; k < 5; k++) begin
            chk4($sformatf("t2.g%0d", k), 32'(1) << order4[k], order4[k], 1);
            tick();
            chk4($sformatf("t2.h%0d", k), 32'(1) << order4[k], order4[k], 1);
            tick();
            ack = 1'b1;
            if (k == 4) req = '0;
            #1;
            check($sformatf("t2.mack%0d", k), 32'(mack), 32'(1) << order4[k]);
            tick();
            ack = 1'b0;
        end
        chk4("t2.idle", 0, 0, 0);

        // single master held across ack, then drop, then ack in IDLE
        req = 4'b0010;
        tick();
        chk4("t3.grant", 32'h2, 1, 1);
        ack = 1'b1;
        tick();
        chk4("t3.regrant", 32'h2, 1, 1);
        ack = 1'b0;
        req = '0;
        tick();
        chk4("t3.drop_idle", 0, 0, 0);
        ack = 1'b1;
        #1;
        check("t3.idle_ack", 32'(mack), 0);
        tick();
        chk4("t3.still_idle", 0, 0, 0);
        ack = 1'b0;

        // master 3 drops req mid-BUSY, pointer wraps to 0
        req = 4'b1000;
        tick();
        chk4("t4.grant3", 32'h8, 3, 1);
        req = 4'b0011;
        #1;
        check("t4.no_ack", 32'(mack), 0);
        tick();
        chk4("t4.wrap", 32'h1, 0, 1);
        ack = 1'b1;
        req = '0;
        tick();
        ack = 1'b0;
        chk4("t4.idle", 0, 0, 0);

`ifdef SLAVE_ARB_TIMEOUT_EN
        req = 4'b1100;
        tick();
        chk4("t5.grant", 32'h4, 2, 1);
        for (int unsigned c = 1; c < 16; c++) begin
            tick();
            check($sformatf("t5.hold%0d", c), 32'(grant), 32'h4);
            check($sformatf("t5.err%0d", c), 32'(terr), 0);
        end
        tick();
        check("t5.err_pulse", 32'(terr), 1);
        chk4("t5.after_to", 32'h8, 3, 1);
        tick();
        check("t5.err_clear", 32'(terr), 0);
        for (int unsigned c = 2; c < 16; c++) tick();
        check("t5.hold_lim", 32'(grant), 32'h8);
        ack = 1'b1;
        #1;
        check("t5.lim_mack", 32'(mack), 32'h8);
        tick();
        ack = 1'b0;
        check("t5.lim_noerr", 32'(terr), 0);
        chk4("t5.lim_next", 32'h4, 2, 1);
        req = '0;
        tick();
        chk4("t5.idle", 0, 0, 0);
`else
        req = 4'b0100;
        tick();
        chk4("t5.grant", 32'h4, 2, 1);
        for (int unsigned c = 0; c < 100; c++) begin
            tick();
            check($sformatf("t5.hold%0d", c), 32'(grant), 32'h4);
            check($sformatf("t5.err%0d", c), 32'(terr), 0);
        end
        req = '0;
        tick();
        chk4("t5.idle", 0, 0, 0);
`endif

        // N=3: rotation over a non-power-of-two count
        req3 = 3'b111;
        tick();
        for (int unsigned k = 0; k < 4; k++) begin
            chk3($sformatf("n3.g%0d", k), 32'(1) << order3[k], order3[k], 1);
            ack3 = 1'b1;
            if (k == 3) req3 = '0;
            #1;
            check($sformatf("n3.mack%0d", k), 32'(mack3), 32'(1) << order3[k]);
            tick();
            ack3 = 1'b0;
        end
        chk3("n3.idle", 0, 0, 0);
        req3 = 3'b010;
        tick();
        chk3("n3.single", 32'h2, 1, 1);
        ack3 = 1'b1;
        tick();
        chk3("n3.regrant", 32'h2, 1, 1);
        ack3 = 1'b0;
        req3 = '0;
        tick();
        chk3("n3.drop", 0, 0, 0);
        ack3 = 1'b1;
        #1;
        check("n3.idle_ack", 32'(mack3), 0);
        ack3 = 1'b0;
        check("n3.err", 32'(terr3), 0);

        // N=1: always master 0
        req1 = 1'b1;
        tick();
        check("n1.grant", 32'(grant1), 1);
        check("n1.idx", 32'(gidx1), 0);
        ack1 = 1'b1;
        #1;
        check("n1.mack", 32'(mack1), 1);
        tick();
        check("n1.regrant", 32'(grant1), 1);
        check("n1.valid", 32'(gvalid1), 1);
        ack1 = 1'b0;
        req1 = 1'b0;
        tick();
        check("n1.idle", 32'(gvalid1), 0);
        check("n1.err", 32'(terr1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
